div_ratio_sequencer: RTL and testbench
======================================

# div_ratio_sequencer

Run-time controller for the even clock-divider path. It produces a divided clock-enable waveform `div_out` whose half-period is programmable in `clk` cycles: half = 1, 2, 3 give the div2, div4, div6 waveforms. It accepts one configuration request at a time over a valid/ready handshake. A new ratio or enable setting is applied only at the end of a low phase, so `div_out` never emits a runt or truncated pulse.

## Interface
- `CNT_W`, 8: width of the half-period value and internal phase counter.
- `clk`  in  1  single clock; all logic on its rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `cfg_valid`  in  1  configuration request present.
- `cfg_ready`  out  1  equals `!pend_valid`; a request is accepted on an edge where `cfg_valid && cfg_ready`.
- `cfg_en`  in  1  1 = run the divider, 0 = stop it.
- `cfg_half`  in  CNT_W  requested half-period in `clk` cycles; ignored when `cfg_en = 0`.
- `div_out`  out  1  registered divided waveform.
- `rise_pulse`  out  1  registered; high for exactly the first cycle of each high phase.
- `cur_half`  out  CNT_W  half-period currently in effect.
- `busy`  out  1  equals `pend_valid`; an accepted request is waiting to be applied.
- `cfg_err`  out  1  one-cycle pulse reporting a rejected request.

## Operation
- **Pending buffer:** one entry holding `pend_en`, `pend_half` and `pend_valid`.
- **Accepting a request:**
  - Acceptance with `cfg_en = 1` and `cfg_half = 0` is a rejection. The handshake completes, `pend_valid` stays 0, and `cfg_err` is 1 in the cycle after the accept edge.
  - Any other acceptance loads the buffer and sets `pend_valid`.
- **FSM states:**
  - OFF: `div_out = 0`, counter held at 0.
  - HIGH: `div_out = 1`, counter `cnt` counts 0..`cur_half`-1.
  - LOW: `div_out = 0`, counter `cnt` counts 0..`cur_half`-1.
- **Transitions:**
  - OFF with `pend_valid`: apply the pending entry. If `pend_en`, go to HIGH with `cnt = 0` and `cur_half = pend_half`. Otherwise stay in OFF. Clear `pend_valid` in both cases.
  - OFF without `pend_valid`: stay in OFF.
  - HIGH with `cnt == cur_half-1`: go to LOW with `cnt = 0`. A pending entry is never applied in HIGH.
  - HIGH otherwise: `cnt + 1`.
  - LOW with `cnt == cur_half-1` and `pend_valid`: apply the entry, clear `pend_valid`, then go to HIGH (`pend_en = 1`, new `cur_half`) or to OFF (`pend_en = 0`).
  - LOW with `cnt == cur_half-1` and no `pend_valid`: go to HIGH with `cnt = 0`.
  - LOW otherwise: `cnt + 1`.
- **Disable:** a disable request leaves `cur_half` unchanged.
- **`rise_pulse`:** 1 in the first HIGH cycle, i.e. the cycle after any transition into HIGH.
- **Simultaneous events:** an accept edge never coincides with an apply, because `cfg_ready = 0` whenever `pend_valid = 1`. An entry applies no earlier than the edge after its accept edge.
- **Counter compare:** width-exact at CNT_W bits. `cur_half = 2^CNT_W-1` is legal.

## Timing
- **Reset:** while `resetn = 0` at an edge, the following take their reset values:
  - state OFF, `cnt = 0`;
  - `div_out = 0`, `rise_pulse = 0`, `cfg_err = 0`;
  - `cur_half = 0`, `pend_valid = 0`, therefore `busy = 0` and `cfg_ready = 1`.
- **Inputs during reset:** `cfg_valid` is ignored while `resetn = 0`; no acceptance occurs.
- **Reset mid-operation:** an in-flight pending entry is discarded. Both `div_out` and `rise_pulse` are 0 after the edge.
- **Start from OFF:** accept at edge N → `busy = 1` after N → `div_out = 1`, `rise_pulse = 1`, `busy = 0` after N+1.
- **Period:** steady-state period is 2·`cur_half` cycles with 50% duty.
- **Ratio change while running:**
  - Accepted in HIGH: applied at the end of the following LOW phase.
  - Accepted in LOW: applied at the end of that LOW phase.
  - Worst-case apply latency is 2·`cur_half` cycles after acceptance.
- **Back-pressure:** `cfg_ready` stays 0 from the edge after acceptance until the apply edge, inclusive of the apply cycle's pre-edge value.

## Test plan
- **Reset values:** hold `resetn = 0` for 3 cycles with `cfg_valid = 1` → all outputs at their reset values, `cfg_ready = 1`, no acceptance. Release → outputs still at their reset values.
- **Start at div2:** from OFF, request `en=1, half=1` at edge N → `div_out` = 1,0,1,0… starting after N+1. `rise_pulse` is high every other cycle. `cur_half = 1`.
- **Ratio change while high:** running half=2 (1100…), request `half=3` during the first HIGH cycle → the current 1,1,0,0 completes, then 1,1,1,0,0,0 repeats. `cfg_ready = 0` until the apply edge.
- **Illegal request:** running half=2, request `en=1, half=0` → `cfg_err` pulses one cycle after acceptance, `busy` stays 0, waveform unchanged.
- **Disable then reset:** running half=3, request `en=0` → the current low phase completes, `div_out` stays 0, `cur_half = 3`. Re-enable with half=2, then assert `resetn = 0` for one edge while in HIGH → `div_out = 0`, `cur_half = 0` next cycle.
- **Back-pressure hold:** running half=3, hold `cfg_valid = 1` for 10 cycles with changing `cfg_half` → only the value present on the accept edge is applied, and a second accept occurs on the first edge where `cfg_ready = 1`.

Source files
------------

// File: rtl/div_ratio_sequencer_if.sv
// Configuration/status bundle for the even clock-divider sequencer.
// master: the configuring agent; slave: the sequencer itself.
interface div_ratio_sequencer_if #(
  parameter int CNT_W = 8
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic             cfg_en;
  logic [CNT_W-1:0] cfg_half;
  logic             div_out;
  logic             rise_pulse;
  logic [CNT_W-1:0] cur_half;
  logic             busy;
  logic             cfg_err;

  modport master (
    output cfg_valid, cfg_en, cfg_half,
    input  cfg_ready, div_out, rise_pulse, cur_half, busy, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_en, cfg_half,
    output cfg_ready, div_out, rise_pulse, cur_half, busy, cfg_err
  );
endinterface

// File: rtl/div_ratio_sequencer.sv
// Run-time controller for the even clock divider. Produces a 50%-duty
// divided enable whose half-period is cur_half clk cycles. New settings
// are buffered in a single pending entry and only take effect at the end
// of a low phase (or immediately when stopped), so no runt pulses appear.
module div_ratio_sequencer #(
  parameter int CNT_W = 8
) (
  input logic                 clk,
  input logic                 resetn,
  div_ratio_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  // One buffered configuration request.
  typedef struct packed {
    logic             en;
    logic [CNT_W-1:0] half;
  } req_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cur_half;
  req_t             pend;
  logic             pend_valid;
  logic             div_out;
  logic             rise_pulse;
  logic             cfg_err;

  logic             accept;
  logic             reject;
  logic             last;

  // Ready only while the pending slot is empty, so an accept can never
  // land on the same edge as an apply.
  assign accept = bus.cfg_valid && !pend_valid;
  // Enabling with a zero half-period has no meaningful waveform.
  assign reject = bus.cfg_en && (bus.cfg_half == '0);
  // Width-exact terminal compare; cur_half is never 0 in HIGH/LOW.
  assign last   = (cnt == (cur_half - CNT_W'(1)));

  // Sequencer FSM, pending buffer and all registered outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= ST_OFF;
      cnt        <= '0;
      cur_half   <= '0;
      pend       <= '0;
      pend_valid <= 1'b0;
      div_out    <= 1'b0;
      rise_pulse <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      rise_pulse <= 1'b0;
      cfg_err    <= 1'b0;

      // Request intake: illegal requests complete the handshake but only
      // raise the error pulse.
      if (accept) begin
        if (reject) begin
          cfg_err <= 1'b1;
        end else begin
          pend_valid <= 1'b1;
          pend.en    <= bus.cfg_en;
          pend.half  <= bus.cfg_half;
        end
      end

      unique case (state)
        ST_OFF: begin
          cnt     <= '0;
          div_out <= 1'b0;
          if (pend_valid) begin
            pend_valid <= 1'b0;
            if (pend.en) begin
              state      <= ST_HIGH;
              cur_half   <= pend.half;
              div_out    <= 1'b1;
              rise_pulse <= 1'b1;
            end
          end
        end

        // Pending entries are deliberately held off during HIGH so the
        // current high pulse is never truncated.
        ST_HIGH: begin
          if (last) begin
            state   <= ST_LOW;
            cnt     <= '0;
            div_out <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ST_LOW: begin
          if (last) begin
            cnt <= '0;
            if (pend_valid) begin
              pend_valid <= 1'b0;
              if (pend.en) begin
                state      <= ST_HIGH;
                cur_half   <= pend.half;
                div_out    <= 1'b1;
                rise_pulse <= 1'b1;
              end else begin
                // Disable keeps the last ratio visible on cur_half.
                state   <= ST_OFF;
                div_out <= 1'b0;
              end
            end else begin
              state      <= ST_HIGH;
              div_out    <= 1'b1;
              rise_pulse <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          state   <= ST_OFF;
          cnt     <= '0;
          div_out <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cfg_ready  = !pend_valid;
  assign bus.busy       = pend_valid;
  assign bus.div_out    = div_out;
  assign bus.rise_pulse = rise_pulse;
  assign bus.cur_half   = cur_half;
  assign bus.cfg_err    = cfg_err;

endmodule

// File: tb/tb_div_ratio_sequencer.sv
// Directed bench for div_ratio_sequencer. The driver pushes the
// hand-computed post-edge outputs for every vector into a scoreboard
// queue; an independent monitor pops and compares after each edge.
module tb_div_ratio_sequencer;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic resetn;

  div_ratio_sequencer_if #(.CNT_W(CNT_W)) bus ();

  div_ratio_sequencer #(.CNT_W(CNT_W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               id;
    logic             div;
    logic             rise;
    logic             busy;
    logic [CNT_W-1:0] half;
    logic             err;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_id = 0;

  task automatic chk(input string nm, input int id, input logic [CNT_W-1:0] act,
                     input logic [CNT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL step%0d %s got %0d expected %0d", id, nm, act, exp);
    end
  endtask

  // Monitor: outputs are sampled 2 time units after each rising edge.
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("div_out",    e.id, CNT_W'(bus.div_out),    CNT_W'(e.div));
      chk("rise_pulse", e.id, CNT_W'(bus.rise_pulse), CNT_W'(e.rise));
      chk("busy",       e.id, CNT_W'(bus.busy),       CNT_W'(e.busy));
      chk("cfg_ready",  e.id, CNT_W'(bus.cfg_ready),  CNT_W'(!e.busy));
      chk("cur_half",   e.id, bus.cur_half,           e.half);
      chk("cfg_err",    e.id, CNT_W'(bus.cfg_err),    CNT_W'(e.err));
    end
  end

  // One vector: inputs for the next edge plus expected outputs after it.
  task automatic s(input logic r, input logic v, input logic en,
                   input logic [CNT_W-1:0] h,
                   input logic ed, input logic er, input logic eb,
                   input logic [CNT_W-1:0] eh, input logic ee);
    exp_t e;
    resetn        = r;
    bus.cfg_valid = v;
    bus.cfg_en    = en;
    bus.cfg_half  = h;
    step_id++;
    e.id = step_id; e.div = ed; e.rise = er; e.busy = eb; e.half = eh; e.err = ee;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with cfg_valid asserted: nothing is accepted.
    repeat (3) s(0, 1, 1, 5,   0, 0, 0, 0, 0);
    repeat (2) s(1, 0, 0, 0,   0, 0, 0, 0, 0);

    // Start at div2 from OFF.
    s(1, 1, 1, 1,   0, 0, 1, 1'b0, 0);
    s(1, 0, 0, 0,   1, 1, 0, 1, 0);
    s(1, 0, 0, 0,   0, 0, 0, 1, 0);
    s(1, 0, 0, 0,   1, 1, 0, 1, 0);
    s(1, 0, 0, 0,   0, 0, 0, 1, 0);
    s(1, 0, 0, 0,   1, 1, 0, 1, 0);

    // Change to half=2 while high.
    s(1, 1, 1, 2,   0, 0, 1, 1, 0);
    s(1, 0, 0, 0,   1, 1, 0, 2, 0);
    s(1, 0, 0, 0,   1, 0, 0, 2, 0);
    s(1, 0, 0, 0,   0, 0, 0, 2, 0);
    s(1, 0, 0, 0,   0, 0, 0, 2, 0);
    s(1, 0, 0, 0,   1, 1, 0, 2, 0);

    // Request half=3 in the first HIGH cycle: 1,1,0,0 completes first.
    s(1, 1, 1, 3,   1, 0, 1, 2, 0);
    s(1, 0, 0, 0,   0, 0, 1, 2, 0);
    s(1, 0, 0, 0,   0, 0, 1, 2, 0);
    s(1, 0, 0, 0,   1, 1, 0, 3, 0);
    s(1, 0, 0, 0,   1, 0, 0, 3, 0);
    s(1, 0, 0, 0,   1, 0, 0, 3, 0);
    repeat (3) s(1, 0, 0, 0,   0, 0, 0, 3, 0);
    s(1, 0, 0, 0,   1, 1, 0, 3, 0);

    // Illegal request: error pulse, waveform untouched.
    s(1, 1, 1, 0,   1, 0, 0, 3, 1);
    s(1, 0, 0, 0,   1, 0, 0, 3, 0);
    repeat (3) s(1, 0, 0, 0,   0, 0, 0, 3, 0);
    s(1, 0, 0, 0,   1, 1, 0, 3, 0);

    // Back-pressure: cfg_valid held 10 edges with changing half.
    s(1, 1, 1, 2,   1, 0, 1, 3, 0);
    s(1, 1, 1, 5,   1, 0, 1, 3, 0);
    s(1, 1, 1, 6,   0, 0, 1, 3, 0);
    s(1, 1, 1, 7,   0, 0, 1, 3, 0);
    s(1, 1, 1, 8,   0, 0, 1, 3, 0);
    s(1, 1, 1, 9,   1, 1, 0, 2, 0);
    s(1, 1, 1, 1,   1, 0, 1, 2, 0);
    s(1, 1, 1, 3,   0, 0, 1, 2, 0);
    s(1, 1, 1, 4,   0, 0, 1, 2, 0);
    s(1, 1, 1, 5,   1, 1, 0, 1, 0);
    s(1, 0, 0, 0,   0, 0, 0, 1, 0);

    // Back to half=3, then disable.
    s(1, 1, 1, 3,   1, 1, 1, 1, 0);
    s(1, 0, 0, 0,   0, 0, 1, 1, 0);
    s(1, 0, 0, 0,   1, 1, 0, 3, 0);
    s(1, 0, 0, 0,   1, 0, 0, 3, 0);
    s(1, 0, 0, 0,   1, 0, 0, 3, 0);
    s(1, 1, 0, 7,   0, 0, 1, 3, 0);
    s(1, 0, 0, 0,   0, 0, 1, 3, 0);
    s(1, 0, 0, 0,   0, 0, 1, 3, 0);
    repeat (3) s(1, 0, 0, 0,   0, 0, 0, 3, 0);

    // Re-enable with half=2, reset while high.
    s(1, 1, 1, 2,   0, 0, 1, 3, 0);
    s(1, 0, 0, 0,   1, 1, 0, 2, 0);
    s(1, 0, 0, 0,   1, 0, 0, 2, 0);
    s(0, 0, 0, 0,   0, 0, 0, 0, 0);
    repeat (2) s(1, 0, 0, 0,   0, 0, 0, 0, 0);

    // Largest half-period: 255 high, 255 low.
    s(1, 1, 1, 255,   0, 0, 1, 0, 0);
    s(1, 0, 0, 0,     1, 1, 0, 255, 0);
    repeat (254) s(1, 0, 0, 0,   1, 0, 0, 255, 0);
    repeat (255) s(1, 0, 0, 0,   0, 0, 0, 255, 0);
    s(1, 0, 0, 0,     1, 1, 0, 255, 0);

    // Reset with a pending entry in flight: the entry is discarded.
    s(1, 1, 1, 4,   1, 0, 1, 255, 0);
    s(0, 0, 0, 0,   0, 0, 0, 0, 0);
    repeat (3) s(1, 0, 0, 0,   0, 0, 0, 0, 0);

    // Drain the scoreboard.
    repeat (2) @(posedge clk);
    #3;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain queue_left %0d expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
